// File: rtl/mem_bus_if.sv
// CPU-side request/response bus of mem_bus: the core drives requests,
// the slave returns registered read data, a valid strobe and an error strobe.
interface mem_bus_if;
    logic        ren;
    logic        wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        bus_err;

    modport master (
        output ren, wen, addr, wdata, wmask,
        input  rdata, rd_valid, bus_err
    );

    modport slave (
        input  ren, wen, addr, wdata, wmask,
        output rdata, rd_valid, bus_err
    );
endinterface

// File: rtl/mem_bus.sv
// Memory and I/O bus slave: word RAM at 0x0000, plus an I/O page holding a
// FIFO-buffered 8N1 UART transmitter, its status register and a cycle counter.
module mem_bus #(
    parameter int RAM_WORDS  = 4096,
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    mem_bus_if.slave bus,
    output logic     uart_tx
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int BW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [16:0]   RAM_BYTES     = 17'(RAM_WORDS * 4);
    localparam logic [BW-1:0] BAUD_RELOAD   = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [13:0]   WORD_UDATA    = 14'h2000;
    localparam logic [13:0]   WORD_USTAT    = 14'h2001;
    localparam logic [13:0]   WORD_CYCLES   = 14'h2002;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Storage arrays (no reset: RAM survives reset, FIFO slots are rewritten before use)
    logic [31:0] ram_q  [RAM_WORDS];
    logic [7:0]  fifo_q [FIFO_DEPTH];

    // Registered state
    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          uart_tx_q, uart_tx_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rd_valid_q, rd_valid_d;
    logic          bus_err_q, bus_err_d;

    // Combinational decode / control
    logic [13:0]       word;
    logic [RAM_AW-1:0] ram_idx;
    logic              hit_ram, hit_udata, hit_ustat, hit_cycles;
    logic              hit_wr_ok, hit_rd_ok;
    logic              do_wr, do_rd;
    logic              fifo_full, fifo_empty, uart_busy;
    logic              push_req, push, pop;
    logic              ram_we;
    logic [3:0]        lane_we;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[1:0];

    // Address decode
    always_comb begin
        word       = bus.addr[15:2];
        ram_idx    = bus.addr[RAM_AW+1:2];
        hit_ram    = ({1'b0, bus.addr} < RAM_BYTES);
        hit_udata  = (word == WORD_UDATA);
        hit_ustat  = (word == WORD_USTAT);
        hit_cycles = (word == WORD_CYCLES);
        hit_wr_ok  = hit_ram | hit_udata;
        hit_rd_ok  = hit_ram | hit_udata | hit_ustat | hit_cycles;
    end

    // Request qualification, FIFO handshake and error detection
    always_comb begin
        do_wr      = bus.wen;
        do_rd      = bus.ren & ~bus.wen;
        fifo_full  = (count_q == FIFO_FULL_CNT);
        fifo_empty = (count_q == {CW{1'b0}});
        uart_busy  = (state_q != ST_IDLE);
        pop        = ~uart_busy & ~fifo_empty;
        push_req   = do_wr & hit_udata & bus.wmask[3];
        // A full FIFO still takes the byte when the transmitter frees a slot this cycle
        push       = push_req & (~fifo_full | pop);
        ram_we     = do_wr & hit_ram;
        lane_we    = {bus.wmask[0], bus.wmask[1], bus.wmask[2], bus.wmask[3]} & {4{ram_we}};
        bus_err_d  = (do_wr & ~hit_wr_ok)
                   | (do_rd & ~hit_rd_ok)
                   | (bus.ren & bus.wen)
                   | (push_req & ~push);
    end

    // Read data mux and cycle counter
    always_comb begin
        rd_word = 32'h0000_0000;
        if (hit_ram) begin
            rd_word = ram_q[ram_idx];
        end else if (hit_ustat) begin
            rd_word = {29'd0, uart_busy, fifo_empty, fifo_full};
        end else if (hit_cycles) begin
            rd_word = cycles_q;
        end else begin
            rd_word = 32'h0000_0000;
        end

        if (do_rd) begin
            rdata_d    = rd_word;
            rd_valid_d = 1'b1;
        end else begin
            rdata_d    = rdata_q;
            rd_valid_d = 1'b0;
        end

        cycles_d = cycles_q + 32'd1;
    end

    // FIFO pointers and occupancy
    always_comb begin
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // UART transmitter next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = fifo_q[rptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_q == {BW{1'b0}}) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = baud_q - BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == {BW{1'b0}}) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == {BW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_d  = baud_q - BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so uart_tx stays a flop
        case (state_d)
            ST_IDLE:  uart_tx_d = 1'b1;
            ST_START: uart_tx_d = 1'b0;
            ST_DATA:  uart_tx_d = shift_d[bit_d];
            ST_STOP:  uart_tx_d = 1'b1;
            default:  uart_tx_d = 1'b1;
        endcase
    end

    // RAM byte-lane writes
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                ram_q[ram_idx][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
        end
    end

    // FIFO slot write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= bus.wdata[7:0];
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= {BW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            uart_tx_q  <= 1'b1;
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            cycles_q   <= 32'd0;
            rdata_q    <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            cycles_q   <= cycles_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.bus_err  = bus_err_q;
    assign uart_tx      = uart_tx_q;
endmodule

// File: tb/tb_mem_bus.sv
// Randomized bench for mem_bus: a cycle-level reference model of the bus map,
// RAM, TX queue, frame timing and cycle counter checks every output every cycle.
module tb_mem_bus;
    localparam int RAM_WORDS  = 4096;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;

    mem_bus_if bus_if ();

    mem_bus #(
        .RAM_WORDS  (RAM_WORDS),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] ram_m [RAM_WORDS];
    logic [7:0]  txq_m [$];
    int          frame_left_m = 0;
    logic [7:0]  frame_byte_m = 8'h00;
    logic [31:0] cyc_m        = 32'd0;
    logic [31:0] exp_rdata    = 32'd0;
    logic        exp_rd_valid = 1'b0;
    logic        exp_err      = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Serial line level implied by the position inside the current frame
    function automatic logic exp_line();
        int b;
        if (frame_left_m == 0) return 1'b1;
        b = (10 * CLK_DIV - frame_left_m) / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return frame_byte_m[b-1];
        return 1'b1;
    endfunction

    // Advance the model by one edge, clock the DUT, compare every output
    task automatic tick();
        logic [15:0] a;
        logic        r, w, hit_ram, hit_ud, hit_us, hit_cy, pop, push_req, accept;
        logic        busy, empty, full;
        logic [31:0] rd_word;
        int          idx;
        a = bus_if.addr;
        r = bus_if.ren;
        w = bus_if.wen;
        if (rst) begin
            txq_m.delete();
            frame_left_m = 0;
            cyc_m        = 32'd0;
            exp_rdata    = 32'd0;
            exp_rd_valid = 1'b0;
            exp_err      = 1'b0;
        end else begin
            hit_ram  = (int'(a) < RAM_WORDS * 4);
            hit_ud   = (a >> 2) == 16'h2000;
            hit_us   = (a >> 2) == 16'h2001;
            hit_cy   = (a >> 2) == 16'h2002;
            idx      = (int'(a) / 4) % RAM_WORDS;
            busy     = (frame_left_m != 0);
            empty    = (txq_m.size() == 0);
            full     = (txq_m.size() == FIFO_DEPTH);
            pop      = !busy && !empty;
            push_req = w && hit_ud && bus_if.wmask[3];
            accept   = !full || pop;

            if (hit_ram)     rd_word = ram_m[idx];
            else if (hit_us) rd_word = (busy ? 32'd4 : 32'd0) | (empty ? 32'd2 : 32'd0) | (full ? 32'd1 : 32'd0);
            else if (hit_cy) rd_word = cyc_m;
            else             rd_word = 32'd0;

            exp_rd_valid = r && !w;
            if (r && !w) exp_rdata = rd_word;

            exp_err = (w && !(hit_ram || hit_ud))
                   || (r && !w && !(hit_ram || hit_ud || hit_us || hit_cy))
                   || (r && w)
                   || (push_req && !accept);

            if (frame_left_m != 0) frame_left_m--;
            if (pop) begin
                frame_byte_m = txq_m.pop_front();
                frame_left_m = 10 * CLK_DIV;
            end
            if (push_req && accept) txq_m.push_back(bus_if.wdata[7:0]);
            if (w && hit_ram) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus_if.wmask[3-k]) ram_m[idx][8*k +: 8] = bus_if.wdata[8*k +: 8];
                end
            end
            cyc_m = cyc_m + 32'd1;
        end
        @(posedge clk);
        #1;
        check_eq("rdata",    bus_if.rdata, exp_rdata);
        check_eq("rd_valid", 32'(bus_if.rd_valid), 32'(exp_rd_valid));
        check_eq("bus_err",  32'(bus_if.bus_err), 32'(exp_err));
        check_eq("uart_tx",  32'(uart_tx), 32'(exp_line()));
    endtask

    task automatic set_idle();
        bus_if.ren   = 1'b0;
        bus_if.wen   = 1'b0;
        bus_if.addr  = 16'h0000;
        bus_if.wdata = 32'h0000_0000;
        bus_if.wmask = 4'h0;
    endtask

    task automatic op(input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] m);
        bus_if.ren   = r;
        bus_if.wen   = w;
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wmask = m;
        tick();
        set_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [15:0] pick_addr(input int sel);
        logic [15:0] base;
        case (sel)
            0, 1, 2, 3, 4, 5, 6, 7: base = 16'h0100 + 16'(4 * sel);
            8:       base = 16'h3FFC;
            9:       base = 16'h8000;
            10:      base = 16'h8004;
            11:      base = 16'h8008;
            12:      base = 16'h9000;
            13:      base = 16'h800C;
            default: base = 16'h4000;
        endcase
        return base | 16'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] c1, c2;
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_rdata",    bus_if.rdata, 32'd0);
        check_eq("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check_eq("rst_uart_tx",  32'(uart_tx), 32'd1);
        check_eq("rst_bus_err",  32'(bus_if.bus_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 16'h0100 + 16'(4 * i), $urandom, 4'hF);
        op(1'b0, 1'b1, 16'h3FFC, $urandom, 4'hF);

        // Byte lanes
        op(1'b0, 1'b1, 16'h0100, 32'h1122_3344, 4'b1111);
        op(1'b0, 1'b1, 16'h0100, 32'h0000_AA00, 4'b0100);
        op(1'b1, 1'b0, 16'h0100, 32'd0, 4'h0);
        check_eq("lane_rdata", bus_if.rdata, 32'h1122_AA44);
        check_eq("lane_valid", 32'(bus_if.rd_valid), 32'd1);
        idle(1);
        check_eq("lane_valid_drop", 32'(bus_if.rd_valid), 32'd0);

        // Single frame of 0x55
        op(1'b0, 1'b1, 16'h8000, 32'h0000_0055, 4'b1000);
        idle(20);
        op(1'b1, 1'b0, 16'h8004, 32'd0, 4'h0);
        check_eq("stat_busy", 32'(bus_if.rdata[2]), 32'd1);
        idle(40);
        op(1'b1, 1'b0, 16'h8004, 32'd0, 4'h0);
        check_eq("stat_idle", bus_if.rdata, 32'h2);

        // FIFO overflow while busy
        for (int i = 0; i < 6; i++) op(1'b0, 1'b1, 16'h8000, 32'hA0 + 32'(i), 4'b1000);
        check_eq("ovf_err", 32'(bus_if.bus_err), 32'd1);
        op(1'b1, 1'b0, 16'h8004, 32'd0, 4'h0);
        check_eq("ovf_full", 32'(bus_if.rdata[0]), 32'd1);
        idle(5 * (10 * CLK_DIV + 1) + 10);

        // Errors and cycle counter
        op(1'b1, 1'b0, 16'h9000, 32'd0, 4'h0);
        check_eq("unmapped_rdata", bus_if.rdata, 32'd0);
        check_eq("unmapped_err", 32'(bus_if.bus_err), 32'd1);
        op(1'b0, 1'b1, 16'h8008, 32'hFFFF_FFFF, 4'hF);
        check_eq("ro_write_err", 32'(bus_if.bus_err), 32'd1);
        op(1'b1, 1'b0, 16'h8008, 32'd0, 4'h0);
        c1 = bus_if.rdata;
        idle(9);
        op(1'b1, 1'b0, 16'h8008, 32'd0, 4'h0);
        c2 = bus_if.rdata;
        check_eq("cyc_delta", c2 - c1, 32'd10);

        // Reset during DATA
        op(1'b0, 1'b1, 16'h8000, 32'h0000_00C3, 4'b1000);
        op(1'b0, 1'b1, 16'h8000, 32'h0000_003C, 4'b1000);
        idle(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_tx", 32'(uart_tx), 32'd1);
        check_eq("midrst_valid", 32'(bus_if.rd_valid), 32'd0);
        op(1'b1, 1'b0, 16'h8004, 32'd0, 4'h0);
        check_eq("midrst_stat", bus_if.rdata, 32'h2);
        op(1'b1, 1'b0, 16'h0100, 32'd0, 4'h0);
        check_eq("midrst_ram", bus_if.rdata, 32'h1122_AA44);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if (kind <= 3) begin
                op(1'b1, 1'b0, pick_addr($urandom_range(0, 14)), $urandom, 4'($urandom));
            end else if (kind <= 6) begin
                op(1'b0, 1'b1, pick_addr($urandom_range(0, 14)), $urandom, 4'($urandom));
            end else if (kind == 7) begin
                op(1'b1, 1'b1, pick_addr($urandom_range(0, 14)), $urandom, 4'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(10 * (10 * CLK_DIV + 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus.md
# mem_bus

Memory and I/O bus slave sitting directly downstream of the CPU core: it consumes the core's `ren`/`wen`/`addr`/`wdata`/`wmask` requests and returns `rdata`/`rd_valid`. It decodes the 16-bit address into a word-organised RAM (program, data, stack and vectors) and a small I/O page containing a buffered UART transmitter, a status register and a free-running cycle counter.

## Interface
- `RAM_WORDS`, 4096: RAM depth in 32-bit words, mapped from 0x0000. It must be a power of two and at most 8192.
- `CLK_DIV`, 104: clock cycles per UART bit. Minimum value is 2.
- `FIFO_DEPTH`, 4: UART TX FIFO entries. Must be a power of two.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ren`  in  1  read request, sampled each cycle.
- `wen`  in  1  write request, sampled each cycle.
- `addr`  in  16  byte address. Bits [1:0] are ignored for decode.
- `wdata`  in  32  write data. Byte lane k is `wdata[8k+7:8k]`.
- `wmask`  in  4  byte enables. `wmask[3-k]` enables lane k, so 4'b1000 enables lane 0 and 4'b1111 enables the full word.
- `rdata`  out  32  registered read data.
- `rd_valid`  out  1  one-cycle pulse marking `rdata` valid.
- `uart_tx`  out  1  serial output, idle high.
- `bus_err`  out  1  one-cycle pulse on an illegal or dropped access.

## Operation
- **Address map** (`word = addr[15:2]`):
  - RAM: `addr < RAM_WORDS*4`, indexed by `addr[log2(RAM_WORDS)+1:2]`.
  - 0x8000 UART_DATA: write pushes `wdata[7:0]` when `wmask[3]` is set; reads return 0.
  - 0x8004 UART_STAT (read-only): bit0 = FIFO full, bit1 = FIFO empty, bit2 = transmitter busy, bits[31:3] = 0.
  - 0x8008 CYCLES (read-only): 32-bit counter, +1 every cycle, wraps from 0xFFFFFFFF to 0.
  - Any other address is unmapped.
- **RAM write:** each lane with its enable set is written. Lanes with the enable clear keep their old value. `wmask` = 0 is a legal no-op.
- **Error pulses:** `bus_err` pulses for exactly one cycle in each of these cases:
  - a write to an unmapped address or to a read-only register; the write has no effect;
  - a read from an unmapped address, which returns 0;
  - `ren` and `wen` both high; the write wins and no read response is produced;
  - a push to UART_DATA while the FIFO is full and no pop happens in the same cycle; the byte is dropped.
- **TX FIFO:** circular buffer with write and read pointers modulo `FIFO_DEPTH` and a count from 0 to `FIFO_DEPTH`.
  - A push and pop in the same cycle leave the count unchanged.
  - When full, a push is accepted only if a pop occurs in the same cycle.
- **UART FSM:** 8N1, LSB first, with states IDLE, START, DATA, STOP.
  - IDLE: `uart_tx` = 1. If the FIFO is non-empty, pop one byte into the shift register and go to START.
  - START: `uart_tx` = 0 for `CLK_DIV` cycles, then go to DATA.
  - DATA: 8 bits, each held for `CLK_DIV` cycles, with a 3-bit bit index; after bit 7 go to STOP.
  - STOP: `uart_tx` = 1 for `CLK_DIV` cycles, then go to IDLE.
  - Busy means state is not IDLE.
  - The baud counter reloads on every bit boundary.

## Timing
- **Reset values:** `rdata` = 0, `rd_valid` = 0, `uart_tx` = 1, `bus_err` = 0. Reset also sets the FIFO empty, the FSM to IDLE and CYCLES to 0. RAM contents are not cleared.
- **Reset mid-frame:** `uart_tx` is 1 from the first edge with `rst` high, and any queued bytes are lost.
- **Read latency:** 1 cycle.
  - `ren` high at edge N gives `rdata` and `rd_valid` = 1 after edge N; `rd_valid` falls after edge N+1 unless `ren` is high again.
  - Back-to-back reads are supported, one per cycle.
  - `rdata` holds its last value while `rd_valid` is low.
- **CYCLES read:** returns the counter value sampled at the request edge.
- **Writes:** take effect at the request edge; a read of the same word in the next cycle returns the new data.
- **Frame timing:** the UART_DATA write lands at edge N. The pop and the move to START occur at edge N+1. `uart_tx` falls after edge N+1. A full frame lasts `10*CLK_DIV` cycles.
- **Back-to-back frames:** the IDLE-to-START check takes one cycle between frames.
- **Status timing:** UART_STAT reflects the state registered before the read edge.

## Test plan
- **RAM byte lanes:** write 0x11223344 to 0x0100 with `wmask` 4'b1111, then write 0x0000AA00 with `wmask` 4'b0100, then read 0x0100 → `rdata` = 0x1122AA44 with `rd_valid` exactly one cycle after `ren`.
- **UART frame:** with `CLK_DIV` = 4, write 0x55 to 0x8000 → `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. UART_STAT reads bit2 = 1 mid-frame and 0x2 once idle.
- **FIFO overflow:** with the UART busy, push 6 bytes back-to-back → pushes 1–5 are accepted (4 queued plus 1 popped into the shift register), the 6th raises `bus_err`, UART_STAT bit0 = 1, and the transmitted byte order is preserved.
- **Errors and CYCLES:** read 0x9000 → `rdata` = 0 and `bus_err` pulse. Write 0x8008 → `bus_err` pulse and CYCLES unaffected. Two reads of 0x8008 issued 10 cycles apart differ by 10.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA → `uart_tx` = 1 next cycle, UART_STAT = 0x2, `rd_valid` = 0, and RAM data written before reset is still readable.
